// File: rtl/router_mesh_xy.sv
// router_mesh_xy: 5-port mesh router with XY dimension-order routing.
//   Each input port buffers single-flit packets in a DEPTH-entry FIFO.
//   Every output has a round-robin arbiter and a credit counter that
//   tracks free slots in the downstream input FIFO.
//   Port index: 0 local, 1 east(+x), 2 west(-x), 3 north(+y), 4 south(-y).
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   in_data       5 packed input flits, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   in_valid      per-port write strobe
//   credit_out    one-cycle pulse per flit popped from input FIFO p
//   out_data      registered output flits (hold last value when idle)
//   out_valid     registered output valid
//   credit_in     one-cycle pulse returning one credit to output p
//   err_overflow  sticky, per port: write attempted into a full FIFO
//   err_badaddr   sticky: a head flit addressed a node outside the mesh

// Single input FIFO. Pointers carry one extra wrap bit so full and empty
// can be told apart without a separate count.
module router_mesh_xy_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_req,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  not_empty,
    output logic                  overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]           wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  full, push;

    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign not_empty = (wr_ptr != rd_ptr);
    // Full is judged before this cycle's pop, so push+pop while full drops.
    assign push      = push_req && !full;
    assign head      = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_req && full)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

module router_mesh_xy #(
    parameter int                         DATA_WIDTH     = 32,
    parameter int                         X_BITS         = 1,
    parameter int                         Y_BITS         = 2,
    parameter int                         MESH_X         = 2,
    parameter int                         MESH_Y         = 4,
    parameter logic [X_BITS+Y_BITS-1:0]   ROUTER_ADDRESS = '0,
    parameter int                         DEPTH          = 4,
    parameter int                         CREDITS        = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [5*DATA_WIDTH-1:0] in_data,
    input  logic [4:0]              in_valid,
    output logic [4:0]              credit_out,
    output logic [5*DATA_WIDTH-1:0] out_data,
    output logic [4:0]              out_valid,
    input  logic [4:0]              credit_in,
    output logic [4:0]              err_overflow,
    output logic                    err_badaddr
);
    localparam int NP     = 5;
    localparam int ADDR_W = X_BITS + Y_BITS;
    localparam int CW     = $clog2(CREDITS + 1);

    localparam logic [X_BITS-1:0] CUR_X     = ROUTER_ADDRESS[X_BITS-1:0];
    localparam logic [Y_BITS-1:0] CUR_Y     = ROUTER_ADDRESS[ADDR_W-1:X_BITS];
    localparam logic [31:0]       LIM_X     = MESH_X;
    localparam logic [31:0]       LIM_Y     = MESH_Y;
    localparam logic [CW-1:0]     CRED_INIT = CW'(CREDITS);

    logic [NP-1:0][DATA_WIDTH-1:0] in_flit, head, out_q;
    logic [NP-1:0]                 not_empty, bad, pop;
    logic [NP-1:0][2:0]            dir;
    logic [NP-1:0][NP-1:0]         req;      // req[o][i]: input i wants output o
    logic [NP-1:0]                 gnt_vld;
    logic [NP-1:0][2:0]            gnt_idx, rr_ptr;
    logic [NP-1:0][CW-1:0]         credit;

    assign in_flit  = in_data;
    assign out_data = out_q;

    for (genvar p = 0; p < NP; p++) begin : g_port
        logic [X_BITS-1:0] dx;
        logic [Y_BITS-1:0] dy;
        logic [X_BITS:0]   diff_x;
        logic [Y_BITS:0]   diff_y;
        logic              east, west, north, south;

        router_mesh_xy_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push_req  (in_valid[p]),
            .wdata     (in_flit[p]),
            .pop       (pop[p]),
            .head      (head[p]),
            .not_empty (not_empty[p]),
            .overflow  (err_overflow[p])
        );

        assign dx = head[p][X_BITS-1:0];
        assign dy = head[p][ADDR_W-1:X_BITS];

        // Signed-style difference: the extra top bit is the "less than" flag.
        assign diff_x = {1'b0, dx} - {1'b0, CUR_X};
        assign diff_y = {1'b0, dy} - {1'b0, CUR_Y};
        assign west   = diff_x[X_BITS];
        assign east   = !diff_x[X_BITS] && (dx != CUR_X);
        assign south  = diff_y[Y_BITS];
        assign north  = !diff_y[Y_BITS] && (dy != CUR_Y);

        // X is resolved fully before Y is considered.
        assign dir[p] = east  ? 3'd1 :
                        west  ? 3'd2 :
                        north ? 3'd3 :
                        south ? 3'd4 : 3'd0;

        assign bad[p] = not_empty[p] &&
                        (({{(32-X_BITS){1'b0}}, dx} >= LIM_X) ||
                         ({{(32-Y_BITS){1'b0}}, dy} >= LIM_Y));

        for (genvar o = 0; o < NP; o++) begin : g_req
            assign req[o][p] = not_empty[p] && !bad[p] && (dir[p] == 3'(o));
        end
    end

    // Round-robin: first requester at or after rr_ptr[o], wrapping mod 5.
    // A grant needs credit at the start of the cycle.
    always_comb begin
        logic [3:0] idx;
        logic       hit;
        gnt_vld = '0;
        gnt_idx = '0;
        idx     = '0;
        hit     = 1'b0;
        for (int o = 0; o < NP; o++) begin
            hit = 1'b0;
            for (int k = 0; k < NP; k++) begin
                idx = {1'b0, rr_ptr[o]} + 4'(k);
                if (idx >= 4'(NP))
                    idx = idx - 4'(NP);
                if (!hit && req[o][idx[2:0]]) begin
                    hit        = 1'b1;
                    gnt_idx[o] = idx[2:0];
                end
            end
            gnt_vld[o] = hit && (credit[o] != '0);
        end
    end

    // Each input requests a single output, so at most one grant hits it.
    // Bad-address heads are discarded here too.
    always_comb begin
        pop = bad;
        for (int o = 0; o < NP; o++)
            if (gnt_vld[o])
                pop[gnt_idx[o]] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid   <= '0;
            credit_out  <= '0;
            err_badaddr <= 1'b0;
            rr_ptr      <= '0;
            credit      <= {NP{CRED_INIT}};
        end else begin
            credit_out  <= pop;
            err_badaddr <= err_badaddr | (|bad);
            for (int o = 0; o < NP; o++) begin
                out_valid[o] <= gnt_vld[o];
                if (gnt_vld[o]) begin
                    out_q[o]  <= head[gnt_idx[o]];
                    rr_ptr[o] <= (gnt_idx[o] == 3'd4) ? 3'd0 : gnt_idx[o] + 3'd1;
                end
                // Grant and returning credit in one cycle cancel out;
                // a return beyond the initial count is ignored.
                if (gnt_vld[o] && !credit_in[o])
                    credit[o] <= credit[o] - 1'b1;
                else if (!gnt_vld[o] && credit_in[o] && credit[o] != CRED_INIT)
                    credit[o] <= credit[o] + 1'b1;
            end
        end
    end
endmodule
